msk_g16mul_rnd_sched: RTL
=========================

// Module: msk_g16mul_rnd_sched
// PURPOSE
//  Upstream scheduler and randomness source for the masked HPC1 G(16) multiplier.
//  Accepts one multiply start per cycle and drives rnd_ref and rnd_mul from a seeded PRNG.
//  rnd_mul is delay-aligned to the multiplier's latency.
//  Emits strobes marking when inb, ina and the product are valid.
// PARAMETERS
//  D             2   number of shares
//  REF_N_RND     1   fresh bits per SNI refresh (per G16 coordinate)
//  DOM_RND       1   fresh bits per DOM AND layer (per G16 coordinate)
//  REF_RNDLAT    0   refresh randomness-to-input latency, cycles
//  RESEED_PERIOD 0   accepted starts before a reseed is required; 0 = never
//  NLANES        1   xorshift32 lanes; must satisfy 32*NLANES >= 4*(REF_N_RND+DOM_RND)
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    synchronous reset, active-high
//  seed_valid   in   1                    seed offered
//  seed_ready   out  1                    seed accepted when valid&ready
//  seed         in   32*NLANES            lane seeds, lane i = seed[32*i+:32]
//  start_valid  in   1                    request a multiply at this cycle (gadget cycle 0)
//  start_ready  out  1                    start accepted when valid&ready
//  rnd_ref      out  4*REF_N_RND          refresh randomness, valid in accept cycle
//  rnd_mul      out  4*DOM_RND            DOM randomness, valid at accept+1+REF_RNDLAT
//  inb_en       out  1                    drive inb now (accept+REF_RNDLAT)
//  ina_en       out  1                    drive ina now (accept+1+REF_RNDLAT)
//  out_valid    out  1                    product valid (accept+2+REF_RNDLAT)
//  busy         out  1                    at least one op in flight
// BEHAVIOUR
//  - FSM states: UNSEEDED (reset state), RUN, EXPIRED.
//  - UNSEEDED: seed_ready=1, start_ready=0. A seed handshake loads the lanes and moves to RUN.
//  - RUN: seed_ready=1, start_ready=~(seed_valid).
//    - A seed has priority: if seed and start are both valid, the seed is taken, the start stalls, and the state stays RUN.
//  - RUN->EXPIRED when RESEED_PERIOD!=0 and the ops counter reaches RESEED_PERIOD on an accept.
//  - EXPIRED: start_ready=0, seed_ready=1. A seed returns to RUN and clears the counter.
//  - Seeding a lane with all-zero loads 32'h9E3779B9 instead, so no lane is ever zero.
//  - PRNG: each lane is a registered xorshift32 (13,17,5) and advances exactly once per accepted start.
//    - A seed load replaces the state; it does not advance it.
//    - rnd_ref = state bits [4*REF_N_RND-1:0], a registered output.
//    - Bits [4*REF_N_RND +: 4*DOM_RND] of the same state are captured on accept into a (1+REF_RNDLAT)-deep delay line.
//    - rnd_mul is the delay-line head when its tag is valid, else 0.
//    - No bit is ever issued for two different starts.
//  - Valid tag shift register of depth 2+REF_RNDLAT, with taps at REF_RNDLAT, 1+REF_RNDLAT and 2+REF_RNDLAT.
//    - The taps give inb_en, ina_en and out_valid.
//    - When REF_RNDLAT=0, inb_en is combinational: start_valid&start_ready.
//  - Fully pipelined: back-to-back starts every cycle, with no bubbles.
//  - busy = OR of all tag stages.
//  - ops counter is 32 bits, saturating, incremented per accept.
//  - Reset: clears FSM to UNSEEDED, lane states, counter, tags and the delay line.
//    - Every output is 0 after reset except seed_ready=1.
//    - In-flight ops are dropped: no out_valid follows a mid-operation reset.
//  - A reseed while ops are in flight does not disturb already-captured rnd_mul values.
// STRUCTURE
//  - Shared package msk_sched_pkg: FSM state enum, XS_ZERO_SUB constant, xorshift32 shift triple, width helpers.
//    - Width helpers: RREF_W = 4*REF_N_RND, RMUL_W = 4*DOM_RND.
//  - One sub-module, msk_xorshift32_lane: registered state with load/advance enables, 32-bit output.
//    - It is instantiated NLANES times.
//  - Top level: FSM, counter, tag pipeline, rnd_mul delay line.
// TESTING
//  - Reset, then seed=32'h1 and a start on the next cycle.
//    - rnd_ref = bits[3:0] of 32'h1.
//    - The next state is 32'h00042021.
//    - ina_en and rnd_mul appear 1 cycle after accept, and out_valid 2 cycles after accept.
//  - start_valid held high with no seed loaded -> start_ready=0, no tags, out_valid stays 0.
//  - seed=0 -> lane loads 32'h9E3779B9, and rnd_ref equals its low 4 bits.
//  - RESEED_PERIOD=3 with 4 back-to-back starts.
//    - 3 are accepted and the FSM goes to EXPIRED, with start_ready=0.
//    - A seed restores RUN and the 4th start is accepted.
//  - seed_valid and start_valid in the same RUN cycle -> seed loaded, start stalled one cycle, then accepted using the new state.
//  - rst asserted 1 cycle after an accept -> no ina_en or out_valid for that op, and the FSM is UNSEEDED.
//  - Continuous starts over 1000 cycles; a scoreboard checks that the ref||mul bits per op match a golden xorshift and are never reissued.

Source files
------------

// File: rtl/msk_sched_pkg.sv
// msk_sched_pkg: shared types, constants and helpers for the HPC1 G(16) randomness scheduler
package msk_sched_pkg;
  typedef enum logic [1:0] {ST_UNSEEDED, ST_RUN, ST_EXPIRED} st_e;
  localparam logic [31:0] XS_ZERO_SUB = 32'h9E3779B9;
  localparam int XS_A = 13;
  localparam int XS_B = 17;
  localparam int XS_C = 5;
  function automatic int rref_w(int n);
    return 4 * n;
  endfunction
  function automatic int rmul_w(int n);
    return 4 * n;
  endfunction
  function automatic logic [31:0] xs32(logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << XS_A);
    y = y ^ (y >> XS_B);
    y = y ^ (y << XS_C);
    return y;
  endfunction
endpackage

// File: rtl/msk_g16mul_rnd_sched_lane.sv
// msk_xorshift32_lane: one registered xorshift32 lane with seed-load and advance enables
module msk_xorshift32_lane
  import msk_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [31:0] seed_i,
  output logic [31:0] state_o
);
  logic [31:0] state_q, state_d;
  // a load replaces the state (zero seed substituted), an advance steps it once
  always_comb state_d = load_i ? (seed_i == '0 ? XS_ZERO_SUB : seed_i) : adv_i ? xs32(state_q) : state_q;
  // lane state register
  always_ff @(posedge clk)
    if (rst) state_q <= '0;
    else state_q <= state_d;
  assign state_o = state_q;
endmodule

// File: rtl/msk_g16mul_rnd_sched.sv
// msk_g16mul_rnd_sched: start scheduler and PRNG randomness source for the masked HPC1 G(16) multiplier
module msk_g16mul_rnd_sched
  import msk_sched_pkg::*;
#(
  parameter int D             = 2,
  parameter int REF_N_RND     = 1,
  parameter int DOM_RND       = 1,
  parameter int REF_RNDLAT    = 0,
  parameter int RESEED_PERIOD = 0,
  parameter int NLANES        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          seed_valid,
  output logic                          seed_ready,
  input  logic [32*NLANES-1:0]          seed,
  input  logic                          start_valid,
  output logic                          start_ready,
  output logic [rref_w(REF_N_RND)-1:0]  rnd_ref,
  output logic [rmul_w(DOM_RND)-1:0]    rnd_mul,
  output logic                          inb_en,
  output logic                          ina_en,
  output logic                          out_valid,
  output logic                          busy
);
  localparam int RREF_W = rref_w(REF_N_RND);
  localparam int RMUL_W = rmul_w(DOM_RND);
  localparam int TAG_N  = 2 + REF_RNDLAT;
  localparam int DL_N   = 1 + REF_RNDLAT;
  if (D < 2 || 32 * NLANES < RREF_W + RMUL_W) begin : g_bad_cfg
    $error("msk_g16mul_rnd_sched: invalid D or too few PRNG lanes");
  end
  st_e                  st_q, st_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [TAG_N-1:0]     tag_q;
  logic [RMUL_W-1:0]    dl_q [DL_N];
  logic [32*NLANES-1:0] lanes;
  logic                 acc;
  logic                 unused_lane_bits;
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    msk_xorshift32_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .load_i  (seed_valid),
      .adv_i   (acc),
      .seed_i  (seed[32*i +: 32]),
      .state_o (lanes[32*i +: 32])
    );
  end
  // handshakes, saturating op counter and FSM next state; a seed always wins over a start
  always_comb begin
    start_ready = st_q == ST_RUN && !seed_valid;
    acc = start_valid && start_ready;
    cnt_d = seed_valid ? '0 : (acc && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
    st_d = seed_valid ? ST_RUN
         : (acc && RESEED_PERIOD != 0 && cnt_d == 32'(RESEED_PERIOD)) ? ST_EXPIRED
         : st_q;
  end
  // FSM, counter, valid tags and the rnd_mul delay line
  always_ff @(posedge clk)
    if (rst) begin
      st_q <= ST_UNSEEDED;
      cnt_q <= '0;
      tag_q <= '0;
      for (int k = 0; k < DL_N; k++) dl_q[k] <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      tag_q <= {tag_q[TAG_N-2:0], acc};
      dl_q[0] <= acc ? lanes[RREF_W +: RMUL_W] : '0;
      for (int k = 1; k < DL_N; k++) dl_q[k] <= dl_q[k-1];
    end
  if (REF_RNDLAT == 0) begin : g_inb_comb
    assign inb_en = acc;
  end else begin : g_inb_tag
    assign inb_en = tag_q[REF_RNDLAT-1];
  end
  assign seed_ready = 1'b1;
  assign rnd_ref = lanes[RREF_W-1:0];
  assign ina_en = tag_q[REF_RNDLAT];
  assign out_valid = tag_q[REF_RNDLAT+1];
  assign rnd_mul = ina_en ? dl_q[DL_N-1] : '0;
  assign busy = |tag_q;
  assign unused_lane_bits = ^lanes;
endmodule
